maze_move_ctrl: RTL

//   Sequences one maze move per request: computes the candidate cell with two internal inc_dec
//   (N) instances (X, Y) and rejects out-of-range steps via their invalid flags. Reads the wall
//   map (1 cycle sync read) for legal steps, then commits or rejects the move.

---
 rtl/maze_move_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/maze_move_ctrl.sv
// One maze move per request: step the selected axis, screen off-grid steps,
// look the target cell up in the wall map, then commit or reject the move.

module inc_dec #(
  parameter int N = 4
) (
  input  logic [N-1:0] val_i,
  input  logic         dec_en_i,
  output logic [N-1:0] res_o,
  output logic         invalid_o
);
  localparam logic [N-1:0] ONE = N'(1);

  assign res_o     = dec_en_i ? val_i - ONE : val_i + ONE;
  // A step that would wrap past either grid edge is flagged rather than taken.
  assign invalid_o = dec_en_i ? (val_i == '0) : (val_i == '1);
endmodule

module maze_move_ctrl #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_en_i,
  input  logic [N-1:0]     load_x_i,
  input  logic [N-1:0]     load_y_i,
  input  logic             req_i,
  input  logic [1:0]       dir_i,
  output logic             ready_o,
  output logic             mem_rd_en_o,
  output logic [2*N-1:0]   mem_addr_o,
  input  logic             mem_data_i,
  output logic [N-1:0]     x_o,
  output logic [N-1:0]     y_o,
  output logic             done_o,
  output logic             blocked_o,
  output logic             oob_o,
  output logic [CNT_W-1:0] step_cnt_o
);
  typedef enum logic [2:0] {IDLE, CALC, RD, CHK, RESP} state_t;

  state_t state_q, state_d;

  // Axis index 0 is X, 1 is Y; packing [1] over [0] gives {y, x} directly.
  logic [1:0][N-1:0] pos_q, pos_d, cand_q, cand_d, cand_calc, step_res;
  logic [1:0]        step_inv;
  logic [1:0]        dir_q, dir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0]    mem_addr_q, mem_addr_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              blocked_q, blocked_d, oob_q, oob_d;
  logic              axis, dec_en, inv_sel;

  // Right/left (dir[0]=1) move X; up/left count down.
  assign axis    = ~dir_q[0];
  assign dec_en  = (dir_q == 2'b00) || (dir_q == 2'b11);
  assign inv_sel = step_inv[axis];

  for (genvar g = 0; g < 2; g++) begin : g_ax
    inc_dec #(.N(N)) u_ax (
      .val_i    (pos_q[g]),
      .dec_en_i (dec_en),
      .res_o    (step_res[g]),
      .invalid_o(step_inv[g])
    );
    assign cand_calc[g] = (axis == 1'(g)) ? step_res[g] : pos_q[g];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!load_en_i && req_i) state_d = CALC;
      CALC: state_d = inv_sel ? RESP : RD;
      RD:   state_d = CHK;
      CHK:  state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    done_o  = (state_q == RESP);
  end

  always_comb begin
    pos_d       = pos_q;
    cand_d      = cand_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_en_d = 1'b0;
    blocked_d   = blocked_q;
    oob_d       = oob_q;
    unique case (state_q)
      IDLE: begin
        if (load_en_i) begin
          pos_d = {load_y_i, load_x_i};
          cnt_d = '0;
        end else if (req_i) begin
          dir_d = dir_i;
        end
      end
      CALC: begin
        if (inv_sel) begin
          oob_d     = 1'b1;
          blocked_d = 1'b0;
        end else begin
          cand_d      = cand_calc;
          mem_addr_d  = cand_calc;
          mem_rd_en_d = 1'b1;
        end
      end
      CHK: begin
        oob_d     = 1'b0;
        blocked_d = mem_data_i;
        if (!mem_data_i) begin
          pos_d = cand_q;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q       <= '0;
      cand_q      <= '0;
      dir_q       <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      blocked_q   <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      cand_q      <= cand_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      blocked_q   <= blocked_d;
      oob_q       <= oob_d;
    end
  end

  assign x_o         = pos_q[0];
  assign y_o         = pos_q[1];
  assign mem_addr_o  = mem_addr_q;
  assign mem_rd_en_o = mem_rd_en_q;
  assign blocked_o   = blocked_q;
  assign oob_o       = oob_q;
  assign step_cnt_o  = cnt_q;
endmodule
